// File: rtl/alarm_display_sched_if.sv
// Signal bundle between the display requesters / blink control and the scheduler,
// including the write port of the 16-bit display PIO slave.
interface alarm_display_sched_if;
    logic        req0;
    logic [15:0] data0;
    logic        ack0;
    logic        req1;
    logic [15:0] data1;
    logic        ack1;
    logic        blink_en;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [15:0] shadow;
    logic        blank_phase;
    logic        busy;

    // Requester / control side
    modport master (
        output req0, data0, req1, data1, blink_en,
        input  ack0, ack1, pio_address, pio_chipselect, pio_write_n,
               pio_writedata, shadow, blank_phase, busy
    );

    // Scheduler side
    modport slave (
        input  req0, data0, req1, data1, blink_en,
        output ack0, ack1, pio_address, pio_chipselect, pio_write_n,
               pio_writedata, shadow, blank_phase, busy
    );
endinterface

// File: rtl/alarm_display_sched.sv
// Sole writer of the display PIO: round-robin arbitration of two update requesters
// plus periodic blink writes alternating the shadow value and a blank pattern.
module alarm_display_sched #(
    parameter int unsigned BLINK_DIV   = 25000000,
    parameter logic [15:0] BLANK_VALUE = 16'hFFFF
) (
    input logic                  clk,
    input logic                  reset_n,
    alarm_display_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

    localparam int unsigned      CNT_W = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(BLINK_DIV - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_en_d;
    logic             tick, blink_fall;
    logic             tick_pending, restore_pending;
    logic             last_grant, grant_nxt;
    logic             write_is_req;
    logic             do_grant, do_restore, do_blink;
    logic [15:0]      shadow, wdata;
    logic             blank_phase;

    assign tick       = bus.blink_en && (blink_cnt == TERM);
    assign blink_fall = blink_en_d && !bus.blink_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        do_grant           = 1'b0;
        do_restore         = 1'b0;
        do_blink           = 1'b0;
        grant_nxt          = last_grant;
        bus.pio_chipselect = 1'b0;
        bus.pio_write_n    = 1'b1;
        bus.ack0           = 1'b0;
        bus.ack1           = 1'b0;
        bus.busy           = (state != IDLE);
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    do_grant  = 1'b1;
                    grant_nxt = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
                    state_nxt = WRITE;
                end else if (restore_pending) begin
                    do_restore = 1'b1;
                    state_nxt  = WRITE;
                end else if (tick_pending && bus.blink_en) begin
                    do_blink  = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                bus.pio_chipselect = 1'b1;
                bus.pio_write_n    = 1'b0;
                state_nxt          = write_is_req ? ACK : IDLE;
            end
            ACK: begin
                bus.ack0  = ~last_grant;
                bus.ack1  = last_grant;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Later assignments take priority: a requester grant discards any tick or
    // restore raised in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt       <= '0;
            blink_en_d      <= 1'b0;
            tick_pending    <= 1'b0;
            restore_pending <= 1'b0;
            last_grant      <= 1'b1;
            write_is_req    <= 1'b0;
            shadow          <= '0;
            wdata           <= '0;
            blank_phase     <= 1'b0;
        end else begin
            blink_en_d <= bus.blink_en;
            if (bus.blink_en) blink_cnt <= tick ? '0 : blink_cnt + 1'b1;
            else              blink_cnt <= '0;
            if (tick) tick_pending <= 1'b1;
            if (blink_fall) begin
                tick_pending <= 1'b0;
                if (blank_phase) restore_pending <= 1'b1;
            end
            if (state == IDLE) write_is_req <= do_grant;
            if (do_grant) begin
                shadow          <= grant_nxt ? bus.data1 : bus.data0;
                wdata           <= grant_nxt ? bus.data1 : bus.data0;
                last_grant      <= grant_nxt;
                blank_phase     <= 1'b0;
                tick_pending    <= 1'b0;
                restore_pending <= 1'b0;
            end else if (do_restore) begin
                wdata           <= shadow;
                blank_phase     <= 1'b0;
                restore_pending <= 1'b0;
            end else if (do_blink) begin
                wdata        <= blank_phase ? shadow : BLANK_VALUE;
                blank_phase  <= ~blank_phase;
                tick_pending <= 1'b0;
            end
        end
    end

    assign bus.pio_address   = 2'b00;
    assign bus.pio_writedata = {16'h0000, wdata};
    assign bus.shadow        = shadow;
    assign bus.blank_phase   = blank_phase;
endmodule
